// File: rtl/cam_rgb565_capture.sv
// cam_rgb565_capture
//   Samples an OV7670-style 8-bit camera bus (VSYNC/HREF/DATA) on the pixel
//   clock, packs byte pairs into RGB565 pixels and emits a one-cycle
//   valid/address/data strobe for the downstream RGB565->RGB888 writer.
//   Frame boundaries are tracked, and short/long lines and frame overflow are
//   reported through a sticky error flag.
//
// Optional feature macro: CAP_FRAME_SKIP_EN
//   When defined, only every other captured frame drives o_en/o_frame_done.
//   The FSM and the error checks still run on the skipped frames.
//
// Ports
//   clk          camera pixel clock (all logic on rising edge)
//   rst          asynchronous, active-high reset
//   i_cap_en     level; arms capture at the next frame start
//   i_vsync      camera VSYNC, high = vertical blanking
//   i_href       camera HREF, high = active line bytes
//   i_cam_data   camera byte bus
//   o_en         one-cycle pixel valid strobe
//   o_addr       linear pixel address, 0..H_ACTIVE*V_ACTIVE-1
//   o_data       RGB565 pixel {first byte, second byte}
//   o_frame_done one-cycle pulse at the end of a captured frame
//   o_busy       high while capturing (S_ACTIVE)
//   o_err        sticky error, cleared at the start of each captured frame
//
// States
//   S_IDLE       | not armed; waits for i_cap_en during vertical blanking
//   S_WAIT_VS_LO | armed; waits for VSYNC to fall (start of frame)
//   S_ACTIVE     | capturing pixels until VSYNC rises

module cam_rgb565_capture #(
  parameter int ADDR_W   = 17,
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cap_en,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_cam_data,
  output logic              o_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic [15:0]       o_data,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_err
);

  // Pixel counter carries one extra bit so that a full frame equal to
  // 2^ADDR_W pixels can still be represented as "full".
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

  // Line counter saturates at H_ACTIVE+1 so an over-long line can never
  // wrap back to a value that looks correct.
  localparam int            LW       = $clog2(H_ACTIVE + 2);
  localparam logic [LW-1:0] LINE_OK  = LW'(H_ACTIVE);
  localparam logic [LW-1:0] LINE_SAT = LW'(H_ACTIVE + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_VS_LO = 2'd1,
    S_ACTIVE     = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              phase, phase_n;
  logic [7:0]        hi_byte, hi_byte_n;
  logic [ADDR_W:0]   pix_cnt, pix_cnt_n;
  logic [LW-1:0]     line_cnt, line_cnt_n;
  logic              href_d;
  logic              en_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       data_n;
  logic              frame_done_n;
  logic              err_n;
  logic              out_ok;

`ifdef CAP_FRAME_SKIP_EN
  logic frame_tgl, frame_tgl_n;

  // The toggle flips on entry to each frame; the first frame after reset
  // sees it at 1 and is written, the next one is skipped, and so on.
  assign out_ok = frame_tgl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_tgl <= 1'b0;
    else     frame_tgl <= frame_tgl_n;
  end
`else
  assign out_ok = 1'b1;
`endif

  assign o_busy = (state == S_ACTIVE);

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    hi_byte_n    = hi_byte;
    pix_cnt_n    = pix_cnt;
    line_cnt_n   = line_cnt;
    en_n         = 1'b0;
    addr_n       = o_addr;
    data_n       = o_data;
    frame_done_n = 1'b0;
    err_n        = o_err;
`ifdef CAP_FRAME_SKIP_EN
    frame_tgl_n  = frame_tgl;
`endif

    case (state)
      S_IDLE: begin
        if (i_cap_en && i_vsync) state_n = S_WAIT_VS_LO;
      end

      S_WAIT_VS_LO: begin
        if (!i_vsync) begin
          state_n    = S_ACTIVE;
          pix_cnt_n  = '0;
          phase_n    = 1'b0;
          line_cnt_n = '0;
          err_n      = 1'b0;
`ifdef CAP_FRAME_SKIP_EN
          frame_tgl_n = ~frame_tgl;
`endif
        end
      end

      S_ACTIVE: begin
        if (i_vsync) begin
          // End of frame wins over any byte sampled on the same edge; a
          // half-formed or just-completed pixel is dropped.
          frame_done_n = out_ok;
          state_n      = i_cap_en ? S_WAIT_VS_LO : S_IDLE;
          phase_n      = 1'b0;
          if (i_href) err_n = 1'b1;
        end else if (i_href) begin
          if (!href_d) line_cnt_n = '0;
          if (!phase) begin
            hi_byte_n = i_cam_data;
            phase_n   = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (line_cnt != LINE_SAT) line_cnt_n = line_cnt + 1'b1;
            if (pix_cnt < CAP) begin
              if (out_ok) begin
                en_n   = 1'b1;
                addr_n = pix_cnt[ADDR_W-1:0];
                data_n = {hi_byte, i_cam_data};
              end
              pix_cnt_n = pix_cnt + 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
        end else begin
          phase_n = 1'b0;
          // HREF falling edge: line must hold exactly H_ACTIVE pixels and
          // no dangling first byte.
          if (href_d && ((line_cnt != LINE_OK) || phase)) err_n = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      hi_byte      <= '0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      href_d       <= 1'b0;
      o_en         <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      hi_byte      <= hi_byte_n;
      pix_cnt      <= pix_cnt_n;
      line_cnt     <= line_cnt_n;
      href_d       <= i_href;
      o_en         <= en_n;
      o_addr       <= addr_n;
      o_data       <= data_n;
      o_frame_done <= frame_done_n;
      o_err        <= err_n;
    end
  end

endmodule
